// File: rtl/axis_udiv_pkg.sv
// Shared types and constants for the iterative AXI4-Stream unsigned divider.
package axis_udiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 dbz;
  } result_t;

endpackage

// File: rtl/axis_slot1.sv
// One-entry tvalid/tready holding register. Ready whenever the slot is empty
// and not in reset; the engine empties it with clear when it loads operands.
module axis_slot1
  import axis_udiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign s_tready = !full && !areset;

  // Capture a beat when the slot is empty; clear empties it so the next beat can land.
  always_ff @(posedge aclk) begin
    if (areset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      full <= 1'b1;
      data <= s_tdata;
    end
  end

endmodule

// File: rtl/axis_udiv_iter.sv
// Radix-2 restoring unsigned divider with independent divisor/dividend slots
// and a single non-stallable {quotient, remainder} result beat.
module axis_udiv_iter
  import axis_udiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tuser
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             load, finish;
  logic             div_full, dvd_full;
  logic [WIDTH-1:0] div_slot, dvd_slot;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
  logic [WIDTH:0]   partial;
  logic             take;
  logic [WIDTH-1:0] rem_next, quo_next;
  result_t          result_q;

  axis_slot1 #(.WIDTH(WIDTH)) u_divisor_slot (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_axis_divisor_tvalid),
    .s_tready (s_axis_divisor_tready),
    .s_tdata  (s_axis_divisor_tdata),
    .clear    (load),
    .full     (div_full),
    .data     (div_slot)
  );

  axis_slot1 #(.WIDTH(WIDTH)) u_dividend_slot (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_axis_dividend_tvalid),
    .s_tready (s_axis_dividend_tready),
    .s_tdata  (s_axis_dividend_tdata),
    .clear    (load),
    .full     (dvd_full),
    .data     (dvd_slot)
  );

  // State register; reset drops any in-flight division without producing a beat.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start whenever both operands wait, finish on the last iteration.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_full && dvd_full) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST_ITER) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (div_full && dvd_full) begin
          load    = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One restoring step. The partial remainder stays below the divisor, so the
  // low WIDTH bits of the subtraction are exact whenever the trial succeeds.
  always_comb begin
    partial  = {rem_q, quo_q[WIDTH-1]};
    take     = (partial >= {1'b0, div_q});
    rem_next = take ? (partial[WIDTH-1:0] - div_q) : partial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], take};
  end

  // Engine registers: load operands, then shift/subtract once per BUSY cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dvd_slot;
      div_q <= div_slot;
      cnt_q <= '0;
      dbz_q <= (div_slot == '0);
    end else if (state_q == BUSY) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result register holds the last answer so tdata stays stable between pulses.
  always_ff @(posedge aclk) begin
    if (areset) begin
      result_q <= '0;
    end else if (finish) begin
      result_q.quotient  <= quo_next;
      result_q.remainder <= rem_next;
      result_q.dbz       <= dbz_q;
    end
  end

  assign m_axis_dout_tvalid = (state_q == DONE);
  assign m_axis_dout_tdata  = {result_q.quotient, result_q.remainder};
  assign m_axis_dout_tuser  = result_q.dbz;

endmodule

// File: tb/tb_axis_udiv_iter.sv
// Self-checking bench for axis_udiv_iter: directed corner cases plus random
// operand pairs, compared against plain '/' and '%' arithmetic.
module tb_axis_udiv_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    int          edge_n;
    logic [63:0] data;
    logic        user;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_divisor_tvalid;
  logic          s_axis_divisor_tready;
  logic [W-1:0]  s_axis_divisor_tdata;
  logic          s_axis_dividend_tvalid;
  logic          s_axis_dividend_tready;
  logic [W-1:0]  s_axis_dividend_tdata;
  logic          m_axis_dout_tvalid;
  logic [2*W-1:0] m_axis_dout_tdata;
  logic          m_axis_dout_tuser;

  int    checks = 0;
  int    failures = 0;
  int    edge_cnt = 0;
  int    div_accepts = 0;
  int    dvd_accepts = 0;
  int    div_last_edge = 0;
  int    dvd_last_edge = 0;
  int    div_mark = 0;
  int    dvd_mark = 0;
  int    glitches = 0;
  logic  hold_dvd = 1'b0;
  logic [63:0] last_dout = '0;
  beat_t beats[$];

  axis_udiv_iter #(.WIDTH(W)) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tready  (s_axis_divisor_tready),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tready (s_axis_dividend_tready),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tdata      (m_axis_dout_tdata),
    .m_axis_dout_tuser      (m_axis_dout_tuser)
  );

  // Free-running clock.
  always #5 aclk = ~aclk;

  // Count edges and record every accepted input beat.
  always @(posedge aclk) begin
    edge_cnt = edge_cnt + 1;
    if (s_axis_divisor_tvalid && s_axis_divisor_tready) begin
      div_accepts   = div_accepts + 1;
      div_last_edge = edge_cnt;
    end
    if (s_axis_dividend_tvalid && s_axis_dividend_tready) begin
      dvd_accepts   = dvd_accepts + 1;
      dvd_last_edge = edge_cnt;
    end
  end

  // Collect output beats and watch for tdata moving while tvalid is low.
  always @(negedge aclk) begin
    if (areset) begin
      last_dout = '0;
    end else if (m_axis_dout_tvalid) begin
      beats.push_back('{edge_cnt, m_axis_dout_tdata, m_axis_dout_tuser});
      last_dout = m_axis_dout_tdata;
    end else if (m_axis_dout_tdata !== last_dout) begin
      glitches = glitches + 1;
    end
  end

  // Reference: {dbz, quotient, remainder}; divide-by-zero gives all-ones / dividend.
  function automatic logic [64:0] refDiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    return {1'b0, a / b, a % b};
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; drop each valid once its beat has been taken.
  task automatic stepCycle();
    @(negedge aclk);
    #1;
    if (s_axis_divisor_tvalid && div_accepts != div_mark) s_axis_divisor_tvalid = 1'b0;
    if (s_axis_dividend_tvalid && !hold_dvd && dvd_accepts != dvd_mark) s_axis_dividend_tvalid = 1'b0;
  endtask

  task automatic raiseDivisor(input logic [31:0] d);
    div_mark              = div_accepts;
    s_axis_divisor_tdata  = d;
    s_axis_divisor_tvalid = 1'b1;
  endtask

  task automatic raiseDividend(input logic [31:0] d);
    dvd_mark               = dvd_accepts;
    s_axis_dividend_tdata  = d;
    s_axis_dividend_tvalid = 1'b1;
  endtask

  task automatic waitBeats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) stepCycle();
    checkOutput({tag, "_timeout"}, 64'(beats.size() >= n), 64'd1);
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] b, input int exp_edge);
    logic [64:0] ref_v;
    ref_v = refDiv(a, b);
    if (beats.size() > idx) begin
      checkOutput({tag, "_quo"},  64'(beats[idx].data[63:32]), 64'(ref_v[63:32]));
      checkOutput({tag, "_rem"},  64'(beats[idx].data[31:0]),  64'(ref_v[31:0]));
      checkOutput({tag, "_user"}, 64'(beats[idx].user),        64'(ref_v[64]));
      checkOutput({tag, "_lat"},  64'(beats[idx].edge_n),      64'(exp_edge));
    end
  endtask

  // One division; skew > 0 sends the divisor first, skew < 0 the dividend first.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input int skew);
    beats.delete();
    if (skew > 0) begin
      raiseDivisor(b);
      repeat (skew) stepCycle();
      raiseDividend(a);
    end else if (skew < 0) begin
      raiseDividend(a);
      repeat (-skew) stepCycle();
      raiseDivisor(b);
    end else begin
      raiseDivisor(b);
      raiseDividend(a);
    end
    waitBeats(tag, 1, 3 * LAT);
    checkBeat(tag, 0, a, b, maxi(div_last_edge, dvd_last_edge) + LAT);
    stepCycle();
    checkOutput({tag, "_pulse"}, 64'(m_axis_dout_tvalid), 64'd0);
  endtask

  initial begin
    int          e_a;
    logic [31:0] ra, rb;
    int          r, skew;

    areset                 = 1'b1;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_divisor_tdata   = '0;
    s_axis_dividend_tvalid = 1'b0;
    s_axis_dividend_tdata  = '0;

    // Reset state.
    repeat (3) @(negedge aclk);
    checkOutput("rst_div_tready", 64'(s_axis_divisor_tready), 64'd0);
    checkOutput("rst_dvd_tready", 64'(s_axis_dividend_tready), 64'd0);
    checkOutput("rst_tvalid", 64'(m_axis_dout_tvalid), 64'd0);
    checkOutput("rst_tdata", m_axis_dout_tdata, 64'd0);
    checkOutput("rst_tuser", 64'(m_axis_dout_tuser), 64'd0);
    areset = 1'b0;
    #1;
    checkOutput("rel_div_tready", 64'(s_axis_divisor_tready), 64'd1);
    checkOutput("rel_dvd_tready", 64'(s_axis_dividend_tready), 64'd1);

    // Directed cases.
    applyStimulus("d2222_11", 32'h2222, 32'h11, 1);
    applyStimulus("d1234_0", 32'h1234, 32'h0, 0);
    applyStimulus("dffff_1", 32'hFFFF_FFFF, 32'h1, 0);
    applyStimulus("d7_10", 32'h7, 32'h10, -2);
    applyStimulus("d10_10", 32'h10, 32'h10, 3);

    // Back-to-back: second pair lands during BUSY and loads straight from DONE.
    beats.delete();
    raiseDivisor(32'd13);
    raiseDividend(32'hDEAD_BEEF);
    repeat (6) stepCycle();
    e_a = maxi(div_last_edge, dvd_last_edge);
    raiseDivisor(32'd0);
    raiseDividend(32'h0BAD_F00D);
    repeat (3) stepCycle();
    checkOutput("b2b_div_tready_low", 64'(s_axis_divisor_tready), 64'd0);
    checkOutput("b2b_dvd_tready_low", 64'(s_axis_dividend_tready), 64'd0);
    checkOutput("b2b_accepts", 64'(div_accepts - div_mark), 64'd1);
    waitBeats("b2b", 2, 4 * LAT);
    checkBeat("b2b_first", 0, 32'hDEAD_BEEF, 32'd13, e_a + LAT);
    checkBeat("b2b_second", 1, 32'h0BAD_F00D, 32'd0, e_a + 2 * LAT);

    // Dividend held high across a full slot: must be taken exactly once.
    beats.delete();
    hold_dvd = 1'b1;
    raiseDividend(32'h000A_BCDE);
    repeat (5) stepCycle();
    checkOutput("hold_dvd_tready", 64'(s_axis_dividend_tready), 64'd0);
    checkOutput("hold_dvd_once", 64'(dvd_accepts - dvd_mark), 64'd1);
    s_axis_dividend_tvalid = 1'b0;
    hold_dvd = 1'b0;
    raiseDivisor(32'h1F);
    waitBeats("hold", 1, 3 * LAT);
    checkBeat("hold", 0, 32'h000A_BCDE, 32'h1F, div_last_edge + LAT);
    repeat (40) stepCycle();
    checkOutput("hold_single_beat", 64'(beats.size()), 64'd1);
    checkOutput("hold_no_dup", 64'(dvd_accepts - dvd_mark), 64'd1);
    checkOutput("dout_stable", 64'(glitches), 64'd0);

    // Reset in the middle of an operation discards it and empties the slots.
    beats.delete();
    raiseDivisor(32'd9);
    raiseDividend(32'd12345);
    stepCycle();
    stepCycle();
    e_a = maxi(div_last_edge, dvd_last_edge);
    for (int i = 0; i < 50 && edge_cnt < e_a + 9; i++) stepCycle();
    raiseDivisor(32'd3);
    stepCycle();
    areset = 1'b1;
    repeat (2) stepCycle();
    areset = 1'b0;
    #1;
    checkOutput("mid_rst_div_tready", 64'(s_axis_divisor_tready), 64'd1);
    checkOutput("mid_rst_dvd_tready", 64'(s_axis_dividend_tready), 64'd1);
    repeat (45) stepCycle();
    checkOutput("mid_rst_no_beat", 64'(beats.size()), 64'd0);
    applyStimulus("post_rst_100_7", 32'd100, 32'd7, 0);

    // Random operand pairs with random arrival skew.
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 9));
      ra = $urandom;
      if (r == 0)      rb = 32'd0;
      else if (r < 5)  rb = 32'($urandom_range(1, 255));
      else             rb = $urandom;
      if (r == 5) ra = 32'($urandom_range(0, 300));
      skew = int'($urandom_range(0, 6)) - 3;
      applyStimulus("rand", ra, rb, skew);
    end
    checkOutput("dout_stable_final", 64'(glitches), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
